pipe_stage_buf: RTL and testbench
=================================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter DW, default 160, payload width in bits of one pipeline slot.
REQ-002 Parameter DEPTH, default 2, slot count; SHALL be a power of two, 2..16.
REQ-003 Parameter PCW, default 32, PC width in bits.
REQ-004 Port clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port cpurst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Port up_valid  in  1  upstream stage offers a slot.
REQ-007 Port up_ready  out  1  block accepts a slot this cycle.
REQ-008 Port up_data  in  DW  upstream payload.
REQ-009 Port up_exp  in  1  the offered slot carries an exception.
REQ-010 Port up_pc  in  PCW  PC of the offered slot.
REQ-011 Port dn_valid  out  1  head slot is presented downstream.
REQ-012 Port dn_ready  in  1  downstream consumes the head slot.
REQ-013 Port dn_data  out  DW  head payload; all-zero (NOP) when dn_valid=0.
REQ-014 Port dn_exp  out  1  head exception flag; 0 when dn_valid=0.
REQ-015 Port dn_pc  out  PCW  head PC; holds the last written PC when dn_valid=0.
REQ-016 Port flush  in  1  exception or interrupt kill of all buffered slots.
REQ-017 Port hold  in  1  multicycle-unit stall; blocks upstream acceptance only.
REQ-018 Port count  out  $clog2(DEPTH+1)  current occupancy.

Function
REQ-019 Accept SHALL occur when up_valid & up_ready; consume SHALL occur when dn_valid & dn_ready.
REQ-020 up_ready SHALL be count<DEPTH & !hold & !flush & !exp_block; it SHALL NOT depend combinationally on dn_ready.
REQ-021 dn_valid SHALL be (count!=0) & !flush.
REQ-022 Simultaneous accept and consume SHALL leave count unchanged; at count==DEPTH no accept occurs even when dn_ready=1.
REQ-023 Latency: an accepted slot SHALL be visible on dn_* in the next cycle when the buffer was empty, and SHALL leave in FIFO order.
REQ-024 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH without a gap.
REQ-025 flush SHALL have priority: in the flush cycle no accept or consume occurs; next cycle count=0 and both pointers equal.
REQ-026 exp_block SHALL set on accept of a slot with up_exp=1 and SHALL clear when that slot is consumed or flushed.
REQ-027 hold SHALL NOT stop downstream draining; consume proceeds during hold.
REQ-028 dn_pc SHALL be registered from up_pc on every cycle in which it is accepted, independent of flush.

Reset
REQ-029 On cpurst_n=0: count=0, pointers=0, exp_block=0, dn_pc=0; dn_valid=0, dn_data=0, dn_exp=0 asynchronously.
REQ-030 Release of cpurst_n mid-transfer SHALL leave the block empty, with no slot accepted in the release cycle.
REQ-031 Storage array contents need not be reset; masking by dn_valid is sufficient.

Structure
REQ-032 Package pipe_pkg SHALL hold the default DW, DEPTH and PCW and the NOP payload constant (all-zero).
REQ-033 Storage SHALL be one sub-module, pipe_buf_ram (DEPTH x (DW+1+PCW), one write port, one asynchronous read port).
REQ-034 Control (pointers, count, exp_block, ready/valid) SHALL remain in pipe_stage_buf.

Verification
REQ-035 Reset, then 3 accepts with dn_ready=0 and DEPTH=4 -> count=3, up_ready=1; 4th accept -> count=4, up_ready=0.
REQ-036 DEPTH=2 full, dn_ready=1 and up_valid=1 for 10 cycles -> one consume per cycle, FIFO order kept, pointer wrap exercised, no loss.
REQ-037 count=2, flush pulse with up_valid=1 and dn_ready=1 -> no transfer; next cycle count=0, dn_valid=0, dn_data=0.
REQ-038 Accept a slot with up_exp=1 while up_valid stays high -> up_ready=0 until that slot is consumed, then 1 on the next cycle.
REQ-039 hold=1 with count=2 and dn_ready=1 -> up_ready=0, count goes 2,1,0.
REQ-040 cpurst_n pulsed low asynchronously mid-burst -> outputs zero immediately; after release the first accept reappears with one-cycle latency.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared defaults for the pipeline stage buffer: slot geometry and the NOP payload
// that is driven downstream whenever no slot is presented.
package pipe_pkg;
  localparam int unsigned DW_DEF    = 160;
  localparam int unsigned DEPTH_DEF = 2;
  localparam int unsigned PCW_DEF   = 32;

  localparam logic [DW_DEF-1:0] NOP_DATA = '0;
endpackage

// File: rtl/pipe_buf_ram.sv
// Slot storage: one synchronous write port, one asynchronous read port.
// Contents are never reset; the control logic masks stale entries.
module pipe_buf_ram
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned WW    = DW_DEF + 1 + PCW_DEF,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [WW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [WW-1:0] rdata
);

  logic [WW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage buffer: FIFO of DEPTH slots with flush, hold and
// exception blocking. Downstream outputs are masked to NOP while no slot is valid.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned PCW   = PCW_DEF
) (
  input  logic                       clk,
  input  logic                       cpurst_n,
  input  logic                       up_valid,
  output logic                       up_ready,
  input  logic [DW-1:0]              up_data,
  input  logic                       up_exp,
  input  logic [PCW-1:0]             up_pc,
  output logic                       dn_valid,
  input  logic                       dn_ready,
  output logic [DW-1:0]              dn_data,
  output logic                       dn_exp,
  output logic [PCW-1:0]             dn_pc,
  input  logic                       flush,
  input  logic                       hold,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned WW = DW + 1 + PCW;

  if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("pipe_stage_buf: DEPTH must be a power of two in 2..16");
  end

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           exp_block_q, exp_block_d;
  logic [PCW-1:0] last_pc_q, last_pc_d;
  logic           rst_done_q;
  logic           accept, consume;
  logic [WW-1:0]  rd_word;
  logic [DW-1:0]  head_data;
  logic           head_exp;
  logic [PCW-1:0] head_pc;

  pipe_buf_ram #(
    .DEPTH (DEPTH),
    .WW    (WW),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr_q),
    .wdata ({up_data, up_exp, up_pc}),
    .raddr (rd_ptr_q),
    .rdata (rd_word)
  );

  assign head_data = rd_word[WW-1 -: DW];
  assign head_exp  = rd_word[PCW];
  assign head_pc   = rd_word[PCW-1:0];

  // rst_done_q keeps the reset-release cycle from accepting a slot.
  assign up_ready = rst_done_q & (count_q < CW'(DEPTH)) & ~hold & ~flush & ~exp_block_q;
  assign dn_valid = (count_q != '0) & ~flush;
  assign accept   = up_valid & up_ready;
  assign consume  = dn_valid & dn_ready;

  assign dn_data = dn_valid ? head_data : DW'(NOP_DATA);
  assign dn_exp  = dn_valid & head_exp;
  assign dn_pc   = dn_valid ? head_pc : last_pc_q;
  assign count   = count_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    exp_block_d = exp_block_q;
    last_pc_d   = last_pc_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      exp_block_d = 1'b0;
    end else begin
      if (accept)  wr_ptr_d = wr_ptr_q + AW'(1);
      if (consume) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(accept) - CW'(consume);
      // At most one exception slot is ever buffered, so the head flag identifies it.
      if (consume && head_exp) exp_block_d = 1'b0;
      if (accept && up_exp)    exp_block_d = 1'b1;
    end
    if (accept) last_pc_d = up_pc;
  end

  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      exp_block_q <= 1'b0;
      last_pc_q   <= '0;
      rst_done_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      exp_block_q <= exp_block_d;
      last_pc_q   <= last_pc_d;
      rst_done_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a DEPTH=2 and a DEPTH=4 instance share stimulus and are
// compared against a queue-based reference model plus directed vector tables.
module tb_pipe_stage_buf;
  localparam int unsigned DW  = 32;
  localparam int unsigned PCW = 16;

  logic           clk = 1'b0;
  logic           cpurst_n;
  logic           up_valid, up_exp, dn_ready, flush, hold;
  logic [DW-1:0]  up_data;
  logic [PCW-1:0] up_pc;

  logic           up_ready2, dn_valid2, dn_exp2;
  logic [DW-1:0]  dn_data2;
  logic [PCW-1:0] dn_pc2;
  logic [1:0]     count2;
  logic           up_ready4, dn_valid4, dn_exp4;
  logic [DW-1:0]  dn_data4;
  logic [PCW-1:0] dn_pc4;
  logic [2:0]     count4;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DW(DW), .DEPTH(2), .PCW(PCW)) u_dut2 (
    .clk(clk), .cpurst_n(cpurst_n), .up_valid(up_valid), .up_ready(up_ready2),
    .up_data(up_data), .up_exp(up_exp), .up_pc(up_pc), .dn_valid(dn_valid2),
    .dn_ready(dn_ready), .dn_data(dn_data2), .dn_exp(dn_exp2), .dn_pc(dn_pc2),
    .flush(flush), .hold(hold), .count(count2));

  pipe_stage_buf #(.DW(DW), .DEPTH(4), .PCW(PCW)) u_dut4 (
    .clk(clk), .cpurst_n(cpurst_n), .up_valid(up_valid), .up_ready(up_ready4),
    .up_data(up_data), .up_exp(up_exp), .up_pc(up_pc), .dn_valid(dn_valid4),
    .dn_ready(dn_ready), .dn_data(dn_data4), .dn_exp(dn_exp4), .dn_pc(dn_pc4),
    .flush(flush), .hold(hold), .count(count4));

  typedef struct packed {
    logic [DW-1:0]  d;
    logic           e;
    logic [PCW-1:0] pc;
  } slot_t;

  // Reference model: index 0 is the DEPTH=2 instance, index 1 the DEPTH=4 one.
  slot_t          mq[2][$];
  logic           mexp[2];
  logic [PCW-1:0] mlpc[2];
  bit             started;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       uv, dr, hd, fl;
    logic [2:0] cnt4;
    logic       rdy4, dv4;
    logic [1:0] cnt2;
    logic       rdy2;
  } vec_t;

  vec_t tbl[13];

  function automatic int depth_of(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  function automatic logic exp_ready(input int k);
    return started && (mq[k].size() < depth_of(k)) && !hold && !flush && !mexp[k];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      mexp[k] = 1'b0;
      mlpc[k] = '0;
    end
    started = 0;
  endtask

  task automatic model_edge();
    logic  acc, con;
    slot_t s;
    if (!cpurst_n) return;
    for (int k = 0; k < 2; k++) begin
      acc = up_valid && exp_ready(k);
      con = !flush && (mq[k].size() != 0) && dn_ready;
      if (flush) begin
        mq[k].delete();
        mexp[k] = 1'b0;
      end else begin
        if (con) begin
          s = mq[k].pop_front();
          if (s.e) mexp[k] = 1'b0;
        end
        if (acc) begin
          mq[k].push_back('{d: up_data, e: up_exp, pc: up_pc});
          if (up_exp) mexp[k] = 1'b1;
          mlpc[k] = up_pc;
        end
      end
    end
    started = 1;
  endtask

  task automatic check_dut(input int k, input logic rdy, input logic dv, input logic [DW-1:0] d,
                           input logic ex, input logic [PCW-1:0] pc, input int cnt);
    logic  ev;
    slot_t h;
    string p;
    p  = $sformatf("d%0d", depth_of(k));
    ev = (mq[k].size() != 0) && !flush;
    h  = '0;
    if (mq[k].size() != 0) h = mq[k][0];
    chk({p, ".up_ready"}, 64'(rdy), 64'(exp_ready(k)));
    chk({p, ".dn_valid"}, 64'(dv),  64'(ev));
    chk({p, ".dn_data"},  64'(d),   64'(ev ? h.d : {DW{1'b0}}));
    chk({p, ".dn_exp"},   64'(ex),  64'(ev & h.e));
    chk({p, ".dn_pc"},    64'(pc),  64'(ev ? h.pc : mlpc[k]));
    chk({p, ".count"},    64'(cnt), 64'(mq[k].size()));
  endtask

  task automatic half_check();
    @(negedge clk);
    check_dut(0, up_ready2, dn_valid2, dn_data2, dn_exp2, dn_pc2, int'(count2));
    check_dut(1, up_ready4, dn_valid4, dn_data4, dn_exp4, dn_pc4, int'(count4));
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step();
    half_check();
    edge_step();
  endtask

  task automatic drive(input logic uv, input logic dr, input logic hd, input logic fl, input logic ex);
    up_valid = uv;
    dn_ready = dr;
    hold     = hd;
    flush    = fl;
    up_exp   = ex;
    up_data  = DW'($urandom);
    up_pc    = PCW'($urandom_range(0, 65535));
  endtask

  task automatic drive_random();
    drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 5) == 0,
          $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0);
  endtask

  initial begin
    //            uv    dr    hd    fl    cnt4  rdy4  dv4   cnt2  rdy2
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 2'd0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 2'd1, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 2'd2, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 2'd2, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 2'd2, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 2'd1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 2'd1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 2'd0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 2'd0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 2'd0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 2'd1, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 2'd2, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 2'd0, 1'b1};

    cpurst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #2;
    chk("rst.count4",    64'(count4),    64'd0);
    chk("rst.dn_valid4", 64'(dn_valid4), 64'd0);
    chk("rst.dn_data4",  64'(dn_data4),  64'd0);
    chk("rst.dn_pc4",    64'(dn_pc4),    64'd0);
    step();
    step();

    // Reset released between edges while a slot is offered: nothing may be taken.
    cpurst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    foreach (tbl[i]) begin
      drive(tbl[i].uv, tbl[i].dr, tbl[i].hd, tbl[i].fl, 1'b0);
      half_check();
      chk($sformatf("vec%0d.count4", i),    64'(count4),    64'(tbl[i].cnt4));
      chk($sformatf("vec%0d.up_ready4", i), 64'(up_ready4), 64'(tbl[i].rdy4));
      chk($sformatf("vec%0d.dn_valid4", i), 64'(dn_valid4), 64'(tbl[i].dv4));
      chk($sformatf("vec%0d.count2", i),    64'(count2),    64'(tbl[i].cnt2));
      chk($sformatf("vec%0d.up_ready2", i), 64'(up_ready2), 64'(tbl[i].rdy2));
      edge_step();
    end

    // Exception slot blocks upstream until it is consumed.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    half_check();
    chk("exp.rdy_before", 64'(up_ready4), 64'd1);
    edge_step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      half_check();
      chk("exp.rdy_blocked", 64'(up_ready4), 64'd0);
      edge_step();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    half_check();
    chk("exp.head_flag", 64'(dn_exp4), 64'd1);
    edge_step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    half_check();
    chk("exp.rdy_after", 64'(up_ready4), 64'd1);
    edge_step();

    // DEPTH=2 full, then streaming with pointer wrap.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    half_check();
    chk("stream.full2", 64'(count2), 64'd2);
    edge_step();
    for (int i = 1; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      half_check();
      chk($sformatf("stream%0d.dn_valid2", i), 64'(dn_valid2), 64'd1);
      edge_step();
    end

    for (int i = 0; i < 500; i++) begin
      drive_random();
      step();
    end

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    #2;
    cpurst_n = 1'b0;
    model_reset();
    #1;
    chk("arst.dn_valid4", 64'(dn_valid4), 64'd0);
    chk("arst.dn_data4",  64'(dn_data4),  64'd0);
    chk("arst.count4",    64'(count4),    64'd0);
    chk("arst.dn_pc4",    64'(dn_pc4),    64'd0);
    chk("arst.dn_valid2", 64'(dn_valid2), 64'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    cpurst_n = 1'b1;
    step();
    step();
    half_check();
    chk("arst.first_out4", 64'(dn_valid4), 64'd1);
    edge_step();

    for (int i = 0; i < 300; i++) begin
      drive_random();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
